// File: rtl/gf128_mult_serial_pkg.sv
// gf128_pkg: shared types and helpers for the serial GF(2^128) multiplier.
// Bit order follows GCM: bit[127] is the x^0 coefficient.
package gf128_pkg;

  typedef logic [127:0] gf128_t;

  localparam gf128_t GF128_R =
    128'hE1000000000000000000000000000000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } gf128_state_t;

  // Multiply v by x: shift toward higher powers, fold x^128 back via R.
  function automatic gf128_t gf128_mulx(input gf128_t v);
    return v[0] ? ((v >> 1) ^ GF128_R) : (v >> 1);
  endfunction

endpackage

// File: rtl/gf128_mult_serial_if.sv
// gf128_mult_serial_if: operand/result handshake bundle.
// master drives operands and out_ready; slave is the multiplier.
interface gf128_mult_serial_if;
  import gf128_pkg::*;

  logic   in_valid;
  logic   in_ready;
  gf128_t a;
  gf128_t b;
  logic   acc_mode;
  logic   acc_clr;
  logic   out_valid;
  logic   out_ready;
  gf128_t z;
  gf128_t acc;
  logic   busy;

  modport master (
    output in_valid, a, b, acc_mode, acc_clr, out_ready,
    input  in_ready, out_valid, z, acc, busy
  );

  modport slave (
    input  in_valid, a, b, acc_mode, acc_clr, out_ready,
    output in_ready, out_valid, z, acc, busy
  );

endinterface

// File: rtl/gf128_mult_serial_digit_step.sv
// gf128_digit_step: DIGIT_W unrolled shift-and-add steps of the
// GF(2^128) multiply, consuming x MSB first.
module gf128_digit_step
  import gf128_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  gf128_t x,
  input  gf128_t v,
  input  gf128_t zacc,
  output gf128_t x_next,
  output gf128_t v_next,
  output gf128_t zacc_next
);

  gf128_t xs;
  gf128_t vs;
  gf128_t zs;

  // Chain DIGIT_W bit steps combinationally.
  always_comb begin
    xs = x;
    vs = v;
    zs = zacc;
    for (int i = 0; i < DIGIT_W; i++) begin
      if (xs[127]) zs = zs ^ vs;
      vs = gf128_mulx(vs);
      xs = xs << 1;
    end
    x_next    = xs;
    v_next    = vs;
    zacc_next = zs;
  end

endmodule

// File: rtl/gf128_mult_serial.sv
// gf128_mult_serial: digit-serial GHASH multiplier with accumulator.
// GF128_MULT_SERIAL_BACK2BACK_EN enables DONE->RUN with forwarding.
module gf128_mult_serial
  import gf128_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input logic clk,
  input logic rst,
  gf128_mult_serial_if.slave bus
);

  localparam int NDIG = 128 / DIGIT_W;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (!(DIGIT_W == 1  || DIGIT_W == 2  ||
          DIGIT_W == 4  || DIGIT_W == 8  ||
          DIGIT_W == 16 || DIGIT_W == 32 ||
          DIGIT_W == 64 || DIGIT_W == 128))
    begin : g_bad_digit
      $error("DIGIT_W must be a power of two in 1..128");
    end
  endgenerate

  gf128_state_t state_q;
  gf128_state_t state_d;

  gf128_t x_q;
  gf128_t v_q;
  gf128_t zacc_q;
  gf128_t z_q;
  gf128_t acc_q;
  logic [CW-1:0] cnt_q;
  logic mode_q;

  gf128_t x_n;
  gf128_t v_n;
  gf128_t zacc_n;
  gf128_t acc_eff;
  gf128_t x_load;

  logic rdy;
  logic vld;
  logic last;
  logic in_acc;
  logic out_acc;

  gf128_digit_step #(
    .DIGIT_W (DIGIT_W)
  ) u_step (
    .x         (x_q),
    .v         (v_q),
    .zacc      (zacc_q),
    .x_next    (x_n),
    .v_next    (v_n),
    .zacc_next (zacc_n)
  );

  assign last    = (cnt_q == CW'(NDIG - 1));
  assign in_acc  = rdy & bus.in_valid;
  assign out_acc = vld & bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    vld     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid) state_d = S_RUN;
      end
      S_RUN: begin
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        vld = 1'b1;
`ifdef GF128_MULT_SERIAL_BACK2BACK_EN
        rdy = bus.out_ready;
`endif
        if (bus.out_ready)
          state_d = (rdy && bus.in_valid) ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator value seen by an accepting operand.
  always_comb begin
    acc_eff = acc_q;
`ifdef GF128_MULT_SERIAL_BACK2BACK_EN
    if (state_q == S_DONE && mode_q) acc_eff = z_q;
`endif
    if (bus.acc_clr) acc_eff = '0;
    x_load = bus.acc_mode ? (bus.a ^ acc_eff) : bus.a;
  end

  // Operand load and per-digit iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      v_q    <= '0;
      zacc_q <= '0;
      z_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else if (in_acc) begin
      x_q    <= x_load;
      v_q    <= bus.b;
      zacc_q <= '0;
      cnt_q  <= '0;
      mode_q <= bus.acc_mode;
    end else if (state_q == S_RUN) begin
      x_q    <= x_n;
      v_q    <= v_n;
      zacc_q <= zacc_n;
      cnt_q  <= cnt_q + 1'b1;
      if (last) z_q <= zacc_n;
    end
  end

  // GHASH accumulator; a clear beats a result write.
  always_ff @(posedge clk) begin
    if (rst)                  acc_q <= '0;
    else if (bus.acc_clr)     acc_q <= '0;
    else if (out_acc && mode_q) acc_q <= z_q;
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.z         = z_q;
  assign bus.acc       = acc_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_gf128_mult_serial.sv
// tb_gf128_mult_serial: scoreboard bench for the serial multiplier,
// DIGIT_W 8 as main DUT plus 1 and 128 instances for the sweep.
module tb_gf128_mult_serial;
  import gf128_pkg::*;

  localparam gf128_t H =
    128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks   = 0;
  int failures = 0;
  gf128_t exp_q[$];
  gf128_t acc_model;

  gf128_mult_serial_if bus ();
  gf128_mult_serial_if bus1 ();
  gf128_mult_serial_if bus128 ();

  gf128_mult_serial #(.DIGIT_W(8)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  gf128_mult_serial #(.DIGIT_W(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  gf128_mult_serial #(.DIGIT_W(128)) u_dut128 (
    .clk (clk), .rst (rst), .bus (bus128)
  );

  always #5 clk = ~clk;

  function automatic gf128_t gf_mul(input gf128_t x, input gf128_t y);
    gf128_t r  = 128'hE1000000000000000000000000000000;
    gf128_t zz = '0;
    gf128_t vv = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) zz = zz ^ vv;
      vv = vv[0] ? ((vv >> 1) ^ r) : (vv >> 1);
    end
    return zz;
  endfunction

  function automatic gf128_t rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.a = '0; bus.b = '0;
    bus.acc_mode = 0; bus.acc_clr = 0; bus.out_ready = 0;
    bus1.in_valid = 0; bus1.a = '0; bus1.b = '0;
    bus1.acc_mode = 0; bus1.acc_clr = 0; bus1.out_ready = 0;
    bus128.in_valid = 0; bus128.a = '0; bus128.b = '0;
    bus128.acc_mode = 0; bus128.acc_clr = 0; bus128.out_ready = 0;
  endtask

  task automatic send(input gf128_t a, input gf128_t b,
                      input logic mode, input logic clr);
    bus.a = a; bus.b = b;
    bus.acc_mode = mode; bus.acc_clr = clr;
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0; bus.acc_mode = 0; bus.acc_clr = 0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic retire();
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b exp 0", bus.busy);
    end
    checks++;
    if (bus.z !== '0) begin
      failures++;
      $display("FAIL reset_z: got %h exp 0", bus.z);
    end
    checks++;
    if (bus.acc !== '0) begin
      failures++;
      $display("FAIL reset_acc: got %h exp 0", bus.acc);
    end
  endtask

  task automatic test_identity();
    int lat;
    gf128_t b = 128'h0123456789ABCDEFFEDCBA9876543210;
    gf128_t e;
    exp_q.push_back(b);
    send(128'h80000000000000000000000000000000, b, 0, 0);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL ident_busy: got %b exp 1", bus.busy);
    end
    wait_out(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL ident_latency: got %0d exp 16", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.z !== e) begin
      failures++;
      $display("FAIL ident_z: got %h exp %h", bus.z, e);
    end
    retire();
  endtask

  task automatic test_reduction();
    int lat;
    gf128_t e;
    exp_q.push_back(128'hE1000000000000000000000000000000);
    send(128'h40000000000000000000000000000000,
         128'h00000000000000000000000000000001, 0, 0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (bus.z !== e) begin
      failures++;
      $display("FAIL reduce_z: got %h exp %h", bus.z, e);
    end
    retire();
  endtask

  task automatic test_zero();
    int lat;
    gf128_t e;
    exp_q.push_back('0);
    send('0, rnd128(), 0, 0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (bus.z !== e) begin
      failures++;
      $display("FAIL zero_a_z: got %h exp %h", bus.z, e);
    end
    retire();
    exp_q.push_back('0);
    send(rnd128(), '0, 0, 0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (bus.z !== e) begin
      failures++;
      $display("FAIL zero_b_z: got %h exp %h", bus.z, e);
    end
    retire();
  endtask

  task automatic test_gcm_vector();
    int lat;
    gf128_t e;
    gf128_t c = 128'h0388dace60b6a392f328c2b971b2fe78;
    gf128_t r = 128'h5e2ec746917062882c85b0685353deb7;
    bus.acc_clr = 1;
    tick();
    bus.acc_clr = 0;
    acc_model = '0;
    checks++;
    if (bus.acc !== acc_model) begin
      failures++;
      $display("FAIL gcm_clr_acc: got %h exp 0", bus.acc);
    end
    exp_q.push_back(r);
    send(c, H, 1, 0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (bus.z !== e) begin
      failures++;
      $display("FAIL gcm_z: got %h exp %h", bus.z, e);
    end
    retire();
    acc_model = r;
    checks++;
    if (bus.acc !== acc_model) begin
      failures++;
      $display("FAIL gcm_acc: got %h exp %h", bus.acc, acc_model);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    gf128_t a = rnd128();
    gf128_t e;
    exp_q.push_back(gf_mul(a ^ acc_model, H));
    send(a, H, 1, 0);
    wait_out(lat);
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.z !== e || bus.out_valid !== 1'b1
          || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_c%0d: got z=%h v=%b r=%b exp z=%h v=1 r=0",
                 i, bus.z, bus.out_valid, bus.in_ready, e);
      end
      tick();
    end
    bus.out_ready = 1;
    bus.acc_clr   = 1;
    tick();
    bus.out_ready = 0;
    bus.acc_clr   = 0;
    acc_model = '0;
    checks++;
    if (bus.acc !== acc_model) begin
      failures++;
      $display("FAIL clr_wins_acc: got %h exp 0", bus.acc);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL retire_drop: got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_chain();
    int lat;
    gf128_t a;
    gf128_t e;
    for (int i = 0; i < 4; i++) begin
      a = rnd128();
      // First block clears with the accept, so X is just a.
      if (i == 0) acc_model = '0;
      acc_model = gf_mul(acc_model ^ a, H);
      exp_q.push_back(acc_model);
      send(a, H, 1, (i == 0));
      wait_out(lat);
      e = exp_q.pop_front();
      checks++;
      if (bus.z !== e) begin
        failures++;
        $display("FAIL chain_z%0d: got %h exp %h", i, bus.z, e);
      end
      retire();
      checks++;
      if (bus.acc !== acc_model) begin
        failures++;
        $display("FAIL chain_acc%0d: got %h exp %h",
                 i, bus.acc, acc_model);
      end
    end
  endtask

`ifndef GF128_MULT_SERIAL_BACK2BACK_EN
  task automatic test_bubble();
    int lat;
    gf128_t a0 = rnd128();
    gf128_t a1 = rnd128();
    gf128_t e;
    exp_q.push_back(gf_mul(a0, H));
    exp_q.push_back(gf_mul(a1, H));
    send(a0, H, 0, 0);
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (bus.z !== e) begin
      failures++;
      $display("FAIL bubble_z0: got %h exp %h", bus.z, e);
    end
    bus.a = a1; bus.b = H; bus.in_valid = 1; bus.out_ready = 1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bubble_rdy_done: got %b exp 0", bus.in_ready);
    end
    tick();
    bus.out_ready = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bubble_idle: got v=%b r=%b exp v=0 r=1",
               bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 0;
    wait_out(lat);
    e = exp_q.pop_front();
    checks++;
    if (bus.z !== e || lat !== 16) begin
      failures++;
      $display("FAIL bubble_z1: got %h lat %0d exp %h lat 16",
               bus.z, lat, e);
    end
    retire();
  endtask
`else
  task automatic test_back_to_back();
    int cyc = 0;
    int got = 0;
    int sent = 0;
    int last_cyc = 0;
    logic acc_ok;
    gf128_t e;
    bus.acc_clr = 1;
    tick();
    bus.acc_clr = 0;
    acc_model = '0;
    bus.out_ready = 1;
    bus.b = H;
    bus.acc_mode = 1;
    bus.a = rnd128();
    bus.in_valid = 1;
    while (got < 64 && cyc < 64 * 20 + 100) begin
      if (bus.out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.z !== e) begin
          failures++;
          $display("FAIL b2b_z%0d: got %h exp %h", got, bus.z, e);
        end
        if (got > 0) begin
          // 16 RUN cycles plus the DONE cycle that doubles as accept.
          checks++;
          if (cyc - last_cyc !== 17) begin
            failures++;
            $display("FAIL b2b_gap%0d: got %0d exp 17",
                     got, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      acc_ok = bus.in_ready && bus.in_valid;
      if (acc_ok) begin
        acc_model = gf_mul(acc_model ^ bus.a, H);
        exp_q.push_back(acc_model);
      end
      tick();
      cyc++;
      if (acc_ok) begin
        sent++;
        if (sent < 64) bus.a = rnd128();
        else bus.in_valid = 0;
      end
    end
    checks++;
    if (got !== 64) begin
      failures++;
      $display("FAIL b2b_count: got %0d exp 64", got);
    end
    tick();
    bus.out_ready = 0;
    bus.acc_mode = 0;
    checks++;
    if (bus.acc !== acc_model) begin
      failures++;
      $display("FAIL b2b_acc: got %h exp %h", bus.acc, acc_model);
    end
  endtask
`endif

  task automatic test_reset_mid_run();
    int seen = 0;
    send(rnd128(), H, 1, 0);
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    acc_model = '0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
        || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ctrl: got v=%b r=%b busy=%b exp 0/1/0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    checks++;
    if (bus.acc !== acc_model) begin
      failures++;
      $display("FAIL rst_mid_acc: got %h exp 0", bus.acc);
    end
    for (int i = 0; i < 24; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rst_mid_noout: got %0d valid cycles exp 0", seen);
    end
  endtask

  task automatic test_sweep(input int n);
    gf128_t a;
    gf128_t b;
    gf128_t e;
    gf128_t zs[3];
    int lats[3];
    int exl[3];
    int lat;
    exl[0] = 16; exl[1] = 128; exl[2] = 1;
    bus.out_ready = 1; bus1.out_ready = 1; bus128.out_ready = 1;
    for (int k = 0; k < n; k++) begin
      a = rnd128();
      b = rnd128();
      exp_q.push_back(gf_mul(a, b));
      bus.a = a; bus.b = b; bus.in_valid = 1;
      bus1.a = a; bus1.b = b; bus1.in_valid = 1;
      bus128.a = a; bus128.b = b; bus128.in_valid = 1;
      tick();
      bus.in_valid = 0; bus1.in_valid = 0; bus128.in_valid = 0;
      for (int j = 0; j < 3; j++) begin
        lats[j] = -1;
        zs[j] = 'x;
      end
      lat = 0;
      while ((lats[0] < 0 || lats[1] < 0 || lats[2] < 0)
             && lat < 200) begin
        tick();
        lat++;
        if (bus.out_valid && lats[0] < 0) begin
          lats[0] = lat; zs[0] = bus.z;
        end
        if (bus1.out_valid && lats[1] < 0) begin
          lats[1] = lat; zs[1] = bus1.z;
        end
        if (bus128.out_valid && lats[2] < 0) begin
          lats[2] = lat; zs[2] = bus128.z;
        end
      end
      tick();
      e = exp_q.pop_front();
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (zs[j] !== e) begin
          failures++;
          $display("FAIL sweep_z inst%0d vec%0d: got %h exp %h",
                   j, k, zs[j], e);
        end
        checks++;
        if (lats[j] !== exl[j]) begin
          failures++;
          $display("FAIL sweep_lat inst%0d vec%0d: got %0d exp %0d",
                   j, k, lats[j], exl[j]);
        end
      end
    end
    bus.out_ready = 0; bus1.out_ready = 0; bus128.out_ready = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    acc_model = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    test_reset();
    test_identity();
    test_reduction();
    test_zero();
    test_gcm_vector();
    test_backpressure();
    test_chain();
`ifndef GF128_MULT_SERIAL_BACK2BACK_EN
    test_bubble();
`else
    test_back_to_back();
`endif
    test_reset_mid_run();
    test_sweep(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
